// File: rtl/red_pitaya_daisy_rx_align.sv
// Receive-side deframer for the daisy-chain link. Finds bit alignment by
// pulsing the ISERDES bitslip, finds nibble phase from a training word, then
// rebuilds 16-bit words (least-significant nibble first) and reports lock
// status plus a saturating training-error count.
module red_pitaya_daisy_rx_align #(
  parameter logic [15:0] TRAIN_PAT = 16'h00FF,
  parameter int unsigned LOCK_CNT  = 16,
  parameter int unsigned SLIP_WAIT = 4,
  parameter int unsigned HUNT_LEN  = 8
) (
  input  logic        par_clk_i,
  input  logic        par_rstn_i,
  input  logic [3:0]  nib_i,
  input  logic        cfg_train_i,
  input  logic        relock_i,
  output logic        bitslip_o,
  output logic        lock_o,
  output logic        par_dv_o,
  output logic [15:0] par_dat_o,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [2:0] {
    StHunt,
    StSlip,
    StWait,
    StVerify,
    StLocked
  } state_t;

  state_t      state;
  logic [11:0] sh;
  logic [1:0]  ph;
  logic [15:0] hunt_cnt;
  logic [15:0] wait_cnt;
  logic [7:0]  match_cnt;

  logic [15:0] cw;
  logic        boundary;
  logic        match;

  // Candidate word: current nibble on top, oldest nibble in bits [3:0].
  always_comb begin
    cw       = {nib_i, sh};
    boundary = (ph == 2'd3);
    match    = (cw == TRAIN_PAT);
  end

  // Shift register, phase counter, alignment FSM and all registered outputs.
  always_ff @(posedge par_clk_i) begin
    if (!par_rstn_i) begin
      state     <= StHunt;
      sh        <= '0;
      ph        <= '0;
      hunt_cnt  <= '0;
      wait_cnt  <= '0;
      match_cnt <= '0;
      bitslip_o <= 1'b0;
      lock_o    <= 1'b0;
      par_dv_o  <= 1'b0;
      par_dat_o <= '0;
      err_cnt_o <= '0;
    end else begin
      sh        <= cw[15:4];
      ph        <= ph + 2'd1;
      bitslip_o <= 1'b0;
      par_dv_o  <= 1'b0;

      if (relock_i) begin
        // Relock overrides any match or lock decision made this cycle.
        state     <= StHunt;
        ph        <= '0;
        hunt_cnt  <= '0;
        wait_cnt  <= '0;
        match_cnt <= '0;
        err_cnt_o <= '0;
        lock_o    <= 1'b0;
      end else begin
        unique case (state)
          StHunt: begin
            if (!cfg_train_i) begin
              hunt_cnt <= '0;
            end else if (match) begin
              // Reload phase so this cycle counts as a word boundary.
              ph        <= '0;
              match_cnt <= 8'd1;
              hunt_cnt  <= '0;
              if (LOCK_CNT == 1) begin
                state  <= StLocked;
                lock_o <= 1'b1;
              end else begin
                state <= StVerify;
              end
            end else if (hunt_cnt == 16'(HUNT_LEN - 1)) begin
              // Registered request: bitslip_o is high while in StSlip.
              state     <= StSlip;
              bitslip_o <= 1'b1;
              hunt_cnt  <= '0;
            end else begin
              hunt_cnt <= hunt_cnt + 16'd1;
            end
          end

          StSlip: begin
            state    <= StWait;
            wait_cnt <= '0;
          end

          StWait: begin
            if (wait_cnt == 16'(SLIP_WAIT - 1)) begin
              state    <= StHunt;
              hunt_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end

          StVerify: begin
            if (boundary) begin
              if (cfg_train_i && match) begin
                match_cnt <= match_cnt + 8'd1;
                if (match_cnt == 8'(LOCK_CNT - 1)) begin
                  state  <= StLocked;
                  lock_o <= 1'b1;
                end
              end else begin
                // Phase was wrong or the link stopped training; bit
                // alignment is kept, so no bitslip on this path.
                state    <= StHunt;
                hunt_cnt <= '0;
              end
            end
          end

          StLocked: begin
            if (boundary) begin
              if (cfg_train_i) begin
                if (!match && (err_cnt_o != 16'hFFFF)) begin
                  err_cnt_o <= err_cnt_o + 16'd1;
                end
              end else begin
                // All-zero word is the idle code and is never delivered.
                par_dat_o <= cw;
                par_dv_o  <= (cw != 16'h0000);
              end
            end
          end

          default: begin
            state <= StHunt;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/red_pitaya_daisy_rx_align.md
# red_pitaya_daisy_rx_align

Receive-side deframer for the daisy-chain serial link. It sits in the parallel clock domain behind the receive ISERDES, which produces one 4-bit nibble per parallel clock. Using a training word, it finds the bit alignment (by pulsing the ISERDES bitslip) and the nibble phase. It then rebuilds the 16-bit words that the transmitter sends as four nibbles, least-significant nibble first, and reports lock status and a training-error count.

## Interface
- `TRAIN_PAT`, default 16'h00FF: training word; must be nonzero and must not equal any of its own nibble or bit rotations.
- `LOCK_CNT`, default 16: consecutive matching training words needed to declare lock; allowed range 1..255.
- `SLIP_WAIT`, default 4: idle cycles after each bitslip pulse, to let the ISERDES output settle.
- `HUNT_LEN`, default 8: cycles without a match in HUNT before a bitslip is issued.

Ports:
- `par_clk_i`, in, 1: parallel clock; the only clock.
- `par_rstn_i`, in, 1: reset; synchronous, active-low.
- `nib_i`, in, 4: ISERDES output for this cycle; `nib_i[0]` is the earliest bit.
- `cfg_train_i`, in, 1: 1 = the link is carrying `TRAIN_PAT`; 0 = the link is carrying payload.
- `relock_i`, in, 1: single-cycle pulse that forces re-alignment.
- `bitslip_o`, out, 1: single-cycle bitslip request to the ISERDES.
- `lock_o`, out, 1: alignment achieved.
- `par_dv_o`, out, 1: `par_dat_o` holds a valid payload word.
- `par_dat_o`, out, 16: reconstructed word.
- `err_cnt_o`, out, 16: count of training-word mismatches while locked; saturates.

## Operation
- **Nibble shift register `sh[11:0]`**
  - Each cycle: `sh <= {nib_i, sh[11:4]}`.
  - Candidate word `cw = {nib_i, sh[11:0]}`; the oldest nibble sits in bits [3:0].
- **Phase counter `ph[1:0]`**
  - Increments every cycle.
  - A word boundary occurs when `ph == 3`.
  - It is reloaded so that the cycle producing a HUNT match is a boundary.
- **FSM states:** HUNT, SLIP, WAIT, VERIFY, LOCKED.
  - **HUNT**
    - While `cfg_train_i = 0`: `hunt_cnt` held at 0, no transitions.
    - Otherwise, every cycle:
      - If `cw == TRAIN_PAT`: set `ph <= 0`, `match_cnt <= 1`, go to VERIFY (or straight to LOCKED if `LOCK_CNT == 1`).
      - Else if `hunt_cnt == HUNT_LEN-1`: go to SLIP.
      - Else increment `hunt_cnt`.
  - **SLIP:** `bitslip_o = 1` for exactly this one cycle, then go to WAIT.
  - **WAIT:** count `SLIP_WAIT` cycles, then go to HUNT with `hunt_cnt = 0`. Slipping wraps indefinitely; there is no slip limit.
  - **VERIFY:** on each boundary:
    - `cw == TRAIN_PAT`: increment `match_cnt`; when it reaches `LOCK_CNT`, go to LOCKED.
    - Mismatch, or `cfg_train_i = 0`: go to HUNT with `hunt_cnt = 0`. No bitslip is issued on this transition.
  - **LOCKED**
    - `lock_o = 1`.
    - On each boundary with `cfg_train_i = 1`: if `cw != TRAIN_PAT`, `err_cnt_o` increments, saturating at 16'hFFFF. `par_dv_o` stays 0.
    - On each boundary with `cfg_train_i = 0`:
      - `par_dat_o <= cw`.
      - `par_dv_o <= (cw != 0)`. Word 16'h0000 is the link idle code and is never delivered.
    - Lock is lost only on reset or `relock_i`; mismatches never drop lock.
- **`relock_i`** (any state): next state is HUNT, all counters cleared, `err_cnt_o <= 0`, `lock_o <= 0`. It takes priority over every other transition.
- **Simultaneous events**
  - `relock_i` beats a match or lock decision in the same cycle.
  - Saturated `err_cnt_o` holds at 16'hFFFF.

## Timing
- **Reset values:** `bitslip_o = 0`, `lock_o = 0`, `par_dv_o = 0`, `par_dat_o = 0`, `err_cnt_o = 0`, `sh = 0`, `ph = 0`, state = HUNT.
- **Reset mid-operation:** same values on the next edge; in-flight words are discarded.
- **All outputs are registered.**
- **Data latency:** the last nibble on `nib_i` in cycle t gives `par_dat_o`/`par_dv_o` valid in cycle t+1.
  - `par_dv_o` is a one-cycle pulse, at most once per 4 cycles.
  - `par_dat_o` holds its value between boundaries.
- **Lock latency:** a first match in cycle t0 gives `lock_o = 1` in cycle t0 + 4·(LOCK_CNT−1) + 1.
- **Bitslip spacing:** pulses are separated by at least `SLIP_WAIT + HUNT_LEN + 1` cycles.
- **`relock_i` response:** takes effect in the cycle after it is sampled.

## Test plan
- **Aligned training:** `nib_i` sequence F,F,0,0 repeating, `cfg_train_i = 1`, defaults.
  - Expect no `bitslip_o`.
  - Expect `lock_o` high exactly 61 cycles after the first match cycle.
  - Expect `err_cnt_o = 0`.
- **Bit skew:** bench ISERDES model rotates the stream by 1 bit per bitslip pulse; stream offset 2 bits.
  - Expect exactly 2 `bitslip_o` pulses, each 13+ cycles apart.
  - Expect lock afterwards.
- **Payload:** after lock, `cfg_train_i = 0`, nibbles 4,3,2,1 then 0,0,0,0.
  - Expect `par_dat_o = 16'h1234` with a single `par_dv_o` pulse one cycle after nibble 1.
  - Expect no pulse for the idle word.
- **Errors and relock:** locked, `cfg_train_i = 1`, 3 corrupted words.
  - Expect `err_cnt_o = 3` and `lock_o` still 1.
  - Pulse `relock_i`: next cycle `lock_o = 0`, `err_cnt_o = 0`, state HUNT.
- **Verify failure:** corrupt the 10th training word during VERIFY.
  - Expect return to HUNT with no `bitslip_o`.
  - Expect `lock_o` to stay 0 until 16 fresh matches are seen.
- **Reset mid-payload:** `par_rstn_i = 0` for 1 cycle while locked.
  - Expect all outputs 0 on the next edge.
  - Expect re-lock from training.
